// File: rtl/blake2_sched_pkg.sv
// Shared constants, state encoding and digest-length helper for the BLAKE2s block scheduler.
package blake2_sched_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int MAX_NN      = 32;

    localparam logic [63:0] T_INC = 64'd64;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_BUSY = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    // Index of the final digest byte; nn of 0 or above MAX_NN means a full-length digest.
    function automatic logic [4:0] digest_last(input logic [5:0] nn);
        if (nn == 6'd0 || nn > 6'(MAX_NN))
            return 5'(MAX_NN - 1);
        else
            return 5'(nn - 6'd1);
    endfunction

endpackage

// File: rtl/blake2_block_sched_if.sv
// Host byte, compression-core and digest signals of the block scheduler.
interface blake2_block_sched_if;

    logic        data_v_i;
    logic [7:0]  data_i;
    logic [5:0]  data_idx_i;
    logic        block_first_i;
    logic        block_last_i;
    logic [5:0]  kk_i;
    logic [5:0]  nn_i;
    logic [63:0] ll_i;
    logic        ready_v_o;
    logic        cmp_v_o;
    logic        cmp_ready_i;
    logic        cmp_first_o;
    logic        cmp_last_o;
    logic [63:0] cmp_t_o;
    logic        cmp_done_i;
    logic [3:0]  blk_raddr_i;
    logic [31:0] blk_rdata_o;
    logic [4:0]  hash_idx_o;
    logic [7:0]  hash_byte_i;
    logic        hash_v_o;
    logic [7:0]  hash_o;
    logic        err_o;

    modport slave (
        input  data_v_i, data_i, data_idx_i, block_first_i, block_last_i,
               kk_i, nn_i, ll_i, cmp_ready_i, cmp_done_i, blk_raddr_i, hash_byte_i,
        output ready_v_o, cmp_v_o, cmp_first_o, cmp_last_o, cmp_t_o,
               blk_rdata_o, hash_idx_o, hash_v_o, hash_o, err_o
    );

    modport master (
        output data_v_i, data_i, data_idx_i, block_first_i, block_last_i,
               kk_i, nn_i, ll_i, cmp_ready_i, cmp_done_i, blk_raddr_i, hash_byte_i,
        input  ready_v_o, cmp_v_o, cmp_first_o, cmp_last_o, cmp_t_o,
               blk_rdata_o, hash_idx_o, hash_v_o, hash_o, err_o
    );

endinterface

// File: rtl/blake2_block_buf.sv
// 64x8 message block buffer: one byte write port, one combinational little-endian word read port.
module blake2_block_buf
    import blake2_sched_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [7:0]  wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [7:0] mem [BLOCK_BYTES];
    logic [5:0] base;

    // NOTE: storage carries no reset; every block overwrites all 64 bytes before the core reads it.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign base  = {raddr, 2'b00};
    assign rdata = {mem[base + 6'd3], mem[base + 6'd2], mem[base + 6'd1], mem[base]};

endmodule

// File: rtl/blake2_block_sched.sv
// BLAKE2s block scheduler: buffers blocks, computes t, issues compressions, streams the digest.
// Optional sticky protocol-error flag is built only when BLAKE2_SCHED_ERR_EN is defined.
module blake2_block_sched
    import blake2_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    blake2_block_sched_if.slave   bus
);

    logic [2:0]  st_q;
    logic [63:0] t_q;
    logic [63:0] cmp_t_q;
    logic        first_q;
    logic        last_q;
    logic [4:0]  out_cnt_q;
    logic [7:0]  hash_q;
    logic        hash_v_q;
    logic        accept;
    logic [4:0]  out_last;

    assign bus.ready_v_o   = (st_q == ST_IDLE) || (st_q == ST_FILL);
    assign accept          = bus.data_v_i && bus.ready_v_o;
    assign out_last        = digest_last(bus.nn_i);
    assign bus.cmp_v_o     = (st_q == ST_REQ);
    assign bus.cmp_first_o = first_q;
    assign bus.cmp_last_o  = last_q;
    assign bus.cmp_t_o     = cmp_t_q;
    assign bus.hash_idx_o  = out_cnt_q;
    assign bus.hash_v_o    = hash_v_q;
    assign bus.hash_o      = hash_q;

    blake2_block_buf u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (bus.data_idx_i),
        .wdata (bus.data_i),
        .raddr (bus.blk_raddr_i),
        .rdata (bus.blk_rdata_o)
    );

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= ST_IDLE;
            t_q       <= '0;
            cmp_t_q   <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            out_cnt_q <= '0;
            hash_q    <= '0;
            hash_v_q  <= 1'b0;
        end else begin
            hash_v_q <= 1'b0;
            case (st_q)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        if (bus.data_idx_i == 6'd63) begin
                            st_q    <= ST_REQ;
                            first_q <= bus.block_first_i;
                            last_q  <= bus.block_last_i;
                            // A last block's t is the message length, offset by the key block if keyed.
                            if (bus.block_last_i)
                                cmp_t_q <= bus.ll_i + ((bus.kk_i != 6'd0) ? T_INC : 64'd0);
                            else
                                cmp_t_q <= (bus.block_first_i ? 64'd0 : t_q) + T_INC;
                        end else begin
                            st_q <= ST_FILL;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.cmp_ready_i) begin
                        st_q <= ST_BUSY;
                        if (!last_q)
                            t_q <= cmp_t_q;
                    end
                end
                ST_BUSY: begin
                    if (bus.cmp_done_i)
                        st_q <= last_q ? ST_OUT : ST_FILL;
                end
                ST_OUT: begin
                    hash_q   <= bus.hash_byte_i;
                    hash_v_q <= 1'b1;
                    if (out_cnt_q == out_last) begin
                        out_cnt_q <= '0;
                        t_q       <= '0;
                        st_q      <= ST_IDLE;
                    end else begin
                        out_cnt_q <= out_cnt_q + 5'd1;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BLAKE2_SCHED_ERR_EN
    logic       err_q;
    logic [5:0] prev_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            prev_idx_q <= '0;
        end else begin
            if (accept)
                prev_idx_q <= bus.data_idx_i;
            if ((bus.data_v_i && !bus.ready_v_o) ||
                (bus.cmp_done_i && st_q != ST_BUSY) ||
                (accept && st_q == ST_FILL && bus.data_idx_i != prev_idx_q + 6'd1))
                err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blake2_block_sched.sv
// Directed self-checking bench for blake2_block_sched with a combinational digest-byte model.
module tb_blake2_block_sched;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] pat [64];

    blake2_block_sched_if bus ();

    blake2_block_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Core model: digest byte i is 0xA0 | i.
    assign bus.hash_byte_i = {3'b101, bus.hash_idx_o};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_block(input logic first, input logic last);
        for (int i = 0; i < 64; i++) begin
            bus.data_v_i      = 1'b1;
            bus.data_idx_i    = 6'(i);
            bus.data_i        = pat[i];
            bus.block_first_i = first;
            bus.block_last_i  = last;
            @(negedge clk);
        end
        bus.data_v_i = 1'b0;
    endtask

    task automatic accept_req(input string tag);
        bus.cmp_ready_i = 1'b1;
        @(negedge clk);
        bus.cmp_ready_i = 1'b0;
        check({tag, "_cmp_v_drop"}, 64'(bus.cmp_v_o), 64'd0);
    endtask

    task automatic pulse_done();
        bus.cmp_done_i = 1'b1;
        @(negedge clk);
        bus.cmp_done_i = 1'b0;
    endtask

    task automatic collect(input int n, input string tag);
        check({tag, "_hash_v_d1"}, 64'(bus.hash_v_o), 64'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_hash_v"}, 64'(bus.hash_v_o), 64'd1);
            check({tag, "_hash_o"}, 64'(bus.hash_o), 64'(8'hA0 | 8'(i)));
        end
        @(negedge clk);
        check({tag, "_hash_v_end"}, 64'(bus.hash_v_o), 64'd0);
        check({tag, "_ready_end"}, 64'(bus.ready_v_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_v_i = 0; bus.data_i = 0; bus.data_idx_i = 0;
        bus.block_first_i = 0; bus.block_last_i = 0;
        bus.kk_i = 0; bus.nn_i = 0; bus.ll_i = 0;
        bus.cmp_ready_i = 0; bus.cmp_done_i = 0; bus.blk_raddr_i = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready",    64'(bus.ready_v_o),   64'd1);
        check("rst_cmp_v",    64'(bus.cmp_v_o),     64'd0);
        check("rst_first",    64'(bus.cmp_first_o), 64'd0);
        check("rst_last",     64'(bus.cmp_last_o),  64'd0);
        check("rst_cmp_t",    bus.cmp_t_o,          64'd0);
        check("rst_hash_v",   64'(bus.hash_v_o),    64'd0);
        check("rst_hash_o",   64'(bus.hash_o),      64'd0);
        check("rst_hash_idx", 64'(bus.hash_idx_o),  64'd0);
        check("rst_err",      64'(bus.err_o),       64'd0);

        // Single-block "abc"
        bus.kk_i = 6'd0; bus.nn_i = 6'd32; bus.ll_i = 64'd3;
        for (int i = 0; i < 64; i++) pat[i] = 8'h00;
        pat[0] = 8'h61; pat[1] = 8'h62; pat[2] = 8'h63;
        send_block(1'b1, 1'b1);
        check("abc_cmp_v", 64'(bus.cmp_v_o),     64'd1);
        check("abc_ready", 64'(bus.ready_v_o),   64'd0);
        check("abc_first", 64'(bus.cmp_first_o), 64'd1);
        check("abc_last",  64'(bus.cmp_last_o),  64'd1);
        check("abc_t",     bus.cmp_t_o,          64'd3);
        bus.blk_raddr_i = 4'd0;
        #1 check("abc_word0", 64'(bus.blk_rdata_o), 64'h0063_6261);
        bus.blk_raddr_i = 4'd15;
        #1 check("abc_word15", 64'(bus.blk_rdata_o), 64'h0);
        @(negedge clk);
        accept_req("abc");
        pulse_done();
        collect(32, "abc");

        // Two-block message, ll=100, nn=16
        bus.ll_i = 64'd100; bus.nn_i = 6'd16;
        for (int i = 0; i < 64; i++) pat[i] = 8'(i);
        send_block(1'b1, 1'b0);
        check("two_b0_t",     bus.cmp_t_o,          64'd64);
        check("two_b0_first", 64'(bus.cmp_first_o), 64'd1);
        check("two_b0_last",  64'(bus.cmp_last_o),  64'd0);
        accept_req("two_b0");
        pulse_done();
        check("two_ready_d1",  64'(bus.ready_v_o), 64'd1);
        check("two_hash_v_d1", 64'(bus.hash_v_o),  64'd0);
        for (int i = 0; i < 64; i++) pat[i] = 8'h80 + 8'(i);
        send_block(1'b0, 1'b1);
        check("two_b1_t",     bus.cmp_t_o,          64'd100);
        check("two_b1_first", 64'(bus.cmp_first_o), 64'd0);
        check("two_b1_last",  64'(bus.cmp_last_o),  64'd1);
        bus.blk_raddr_i = 4'd1;
        #1 check("two_word1", 64'(bus.blk_rdata_o), 64'h8786_8584);
        @(negedge clk);
        accept_req("two_b1");
        pulse_done();
        collect(16, "two");

        // Keyed message kk=32, ll=0, nn=0, with backpressure on the last request
        bus.kk_i = 6'd32; bus.ll_i = 64'd0; bus.nn_i = 6'd0;
        for (int i = 0; i < 64; i++) pat[i] = 8'h40 + 8'(i);
        send_block(1'b1, 1'b0);
        check("key_b0_t", bus.cmp_t_o, 64'd64);
        accept_req("key_b0");
        pulse_done();
        for (int i = 0; i < 64; i++) pat[i] = 8'h10 + 8'(i);
        send_block(1'b0, 1'b1);
        check("key_b1_t", bus.cmp_t_o, 64'd64);
        for (int c = 0; c < 5; c++) begin
            bus.data_v_i   = (c == 0);
            bus.data_idx_i = 6'd5;
            bus.data_i     = 8'hFF;
            bus.cmp_done_i = (c == 2);
            @(negedge clk);
            check("bp_cmp_v", 64'(bus.cmp_v_o),   64'd1);
            check("bp_cmp_t", bus.cmp_t_o,        64'd64);
            check("bp_ready", 64'(bus.ready_v_o), 64'd0);
        end
        bus.data_v_i = 1'b0; bus.cmp_done_i = 1'b0;
        bus.blk_raddr_i = 4'd1;
        #1 check("bp_word1_kept", 64'(bus.blk_rdata_o), 64'h1716_1514);
`ifdef BLAKE2_SCHED_ERR_EN
        check("bp_err", 64'(bus.err_o), 64'd1);
`else
        check("bp_err", 64'(bus.err_o), 64'd0);
`endif
        @(negedge clk);
        accept_req("key_b1");
        pulse_done();
        collect(32, "key");

        // Reset mid-OUT, then t_q must restart from zero
        bus.kk_i = 6'd0; bus.nn_i = 6'd8; bus.ll_i = 64'd128;
        send_block(1'b1, 1'b0);
        accept_req("rst_b0");
        pulse_done();
        send_block(1'b0, 1'b1);
        check("rst_b1_t", bus.cmp_t_o, 64'd128);
        accept_req("rst_b1");
        pulse_done();
        repeat (3) @(negedge clk);
        check("mid_out_hash_v", 64'(bus.hash_v_o), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_hash_v",   64'(bus.hash_v_o),   64'd0);
        check("post_rst_ready",    64'(bus.ready_v_o),  64'd1);
        check("post_rst_cmp_v",    64'(bus.cmp_v_o),    64'd0);
        check("post_rst_cmp_t",    bus.cmp_t_o,         64'd0);
        check("post_rst_hash_idx", 64'(bus.hash_idx_o), 64'd0);
        check("post_rst_err",      64'(bus.err_o),      64'd0);
        reset = 1'b0;
        @(negedge clk);
        send_block(1'b0, 1'b0);
        check("post_rst_t", bus.cmp_t_o, 64'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
